// File: rtl/pic24_icsp_pkg.sv
// Shared PIC24 ICSP definitions: command codes, entry keys and target states.
// Used by both the programmer and the pic24icsp_target responder.
package pic24_icsp_pkg;

    localparam logic [3:0]  ICSP_SIX            = 4'b0000;
    localparam logic [3:0]  ICSP_REGOUT         = 4'b0001;
    localparam logic [31:0] ICSP_ENTER_CODE     = 32'h4D434851;
    localparam logic [31:0] ENH_ICSP_ENTER_CODE = 32'h4D434850;

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_KEY     = 4'd1,
        ST_KEYFAIL = 4'd2,
        ST_KEYOK   = 4'd3,
        ST_PRE     = 4'd4,
        ST_FIRST   = 4'd5,
        ST_CMD     = 4'd6,
        ST_SIX     = 4'd7,
        ST_RIDLE   = 4'd8,
        ST_ROUT    = 4'd9,
        ST_DISCARD = 4'd10
    } icsp_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pic24icsp_sync.sv
// Input synchronizers for PGC/PGD/MCLRn plus one-cycle PGC rise/fall strobes.
module pic24icsp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic pgc,
    input  logic pgd,
    input  logic mclrn,
    output logic pgc_s,
    output logic pgd_s,
    output logic mclrn_s,
    output logic pgc_rise,
    output logic pgc_fall
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] pgc_sync_r;
    logic [STAGES-1:0] pgd_sync_r;
    logic [STAGES-1:0] mclrn_sync_r;
    logic              pgc_prev_r;

    // Synchronizer chains and previous-PGC history for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pgc_sync_r   <= '0;
            pgd_sync_r   <= '0;
            mclrn_sync_r <= '0;
            pgc_prev_r   <= 1'b0;
        end else begin
            pgc_sync_r   <= {pgc_sync_r[STAGES-2:0], pgc};
            pgd_sync_r   <= {pgd_sync_r[STAGES-2:0], pgd};
            mclrn_sync_r <= {mclrn_sync_r[STAGES-2:0], mclrn};
            pgc_prev_r   <= pgc_sync_r[STAGES-1];
        end
    end

    assign pgc_s    = pgc_sync_r[STAGES-1];
    assign pgd_s    = pgd_sync_r[STAGES-1];
    assign mclrn_s  = mclrn_sync_r[STAGES-1];
    assign pgc_rise = pgc_s & ~pgc_prev_r;
    assign pgc_fall = ~pgc_s & pgc_prev_r;

endmodule

// File: rtl/pic24icsp_target.sv
// PIC24 ICSP target responder: key entry, SIX/REGOUT decode, register readback.
// Optional ICSP_TGT_ENH_KEY_EN also accepts the enhanced-ICSP key and adds enh_mode.
module pic24icsp_target
    import pic24_icsp_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ICSP_KEY    = 32'h4D434851,
    parameter int          PRE_CLKS    = 9,
    parameter int          REGOUT_IDLE = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        PGCx,
    input  logic        MCLRn,
    input  logic        PGDx_in,
    output logic        PGDx_out,
    output logic        PGDx_oe,
    output logic [23:0] instr,
    output logic        instr_valid,
    output logic        regout_req,
    input  logic [15:0] regout_data,
    output logic        in_icsp,
    output logic        cmd_err
`ifdef ICSP_TGT_ENH_KEY_EN
    ,
    output logic        enh_mode
`endif
);

    localparam int CNT_MAX = max3(32, PRE_CLKS, REGOUT_IDLE);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(31);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(23);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(3);
    localparam logic [CNT_W-1:0] ROUT_BITS = CNT_W'(16);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CLKS - 1);
    localparam logic [CNT_W-1:0] IDLE_N    = CNT_W'(REGOUT_IDLE);

    logic pgc_s, pgd_s, mclrn_s, pgc_rise_s, pgc_fall_s;

    pic24icsp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .pgc      (PGCx),
        .pgd      (PGDx_in),
        .mclrn    (MCLRn),
        .pgc_s    (pgc_s),
        .pgd_s    (pgd_s),
        .mclrn_s  (mclrn_s),
        .pgc_rise (pgc_rise_s),
        .pgc_fall (pgc_fall_s)
    );

    icsp_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      shift_r;
    logic [31:0]      shift_next_s;
    logic [15:0]      rdata_r;
    logic             latch_now_r;
    logic [23:0]      instr_r;
    logic             instr_valid_r;
    logic             regout_req_r;
    logic             cmd_err_r;
    logic             in_icsp_r;
    logic             pgdx_oe_r;
    logic             pgdx_out_r;
`ifdef ICSP_TGT_ENH_KEY_EN
    logic             enh_mode_r;
`endif

    assign shift_next_s = {shift_r[30:0], pgd_s};

    // Target FSM; MCLRn abort outranks any PGC edge seen in the same cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= ST_OFF;
            cnt_r         <= '0;
            shift_r       <= 32'd0;
            rdata_r       <= 16'd0;
            latch_now_r   <= 1'b0;
            instr_r       <= 24'd0;
            instr_valid_r <= 1'b0;
            regout_req_r  <= 1'b0;
            cmd_err_r     <= 1'b0;
            in_icsp_r     <= 1'b0;
            pgdx_oe_r     <= 1'b0;
            pgdx_out_r    <= 1'b0;
`ifdef ICSP_TGT_ENH_KEY_EN
            enh_mode_r    <= 1'b0;
`endif
        end else begin
            instr_valid_r <= 1'b0;
            regout_req_r  <= 1'b0;
            cmd_err_r     <= 1'b0;
            // back end answers regout_req one cycle later
            latch_now_r   <= regout_req_r;
            if (latch_now_r) begin
                rdata_r <= regout_data;
            end
            if (in_icsp_r && !mclrn_s) begin
                state_r     <= ST_KEY;
                cnt_r       <= '0;
                shift_r     <= 32'd0;
                in_icsp_r   <= 1'b0;
                pgdx_oe_r   <= 1'b0;
                pgdx_out_r  <= 1'b0;
                latch_now_r <= 1'b0;
`ifdef ICSP_TGT_ENH_KEY_EN
                enh_mode_r  <= 1'b0;
`endif
            end else begin
                case (state_r)
                    ST_OFF: begin
`ifdef ICSP_TGT_ENH_KEY_EN
                        enh_mode_r <= 1'b0;
`endif
                        if (!mclrn_s) begin
                            state_r <= ST_KEY;
                            cnt_r   <= '0;
                            shift_r <= 32'd0;
                        end
                    end
                    ST_KEY: begin
                        if (mclrn_s) begin
                            state_r <= ST_OFF;
                        end else if (pgc_rise_s) begin
                            shift_r <= shift_next_s;
                            if (cnt_r == KEY_LAST) begin
                                cnt_r <= '0;
                                if (shift_next_s == ICSP_KEY) begin
                                    state_r <= ST_KEYOK;
                                end
`ifdef ICSP_TGT_ENH_KEY_EN
                                else if (shift_next_s == ENH_ICSP_ENTER_CODE) begin
                                    state_r    <= ST_KEYOK;
                                    enh_mode_r <= 1'b1;
                                end
`endif
                                else begin
                                    state_r <= ST_KEYFAIL;
                                end
                            end else begin
                                cnt_r <= cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_KEYFAIL: begin
                        if (mclrn_s) begin
                            state_r <= ST_OFF;
                        end
                    end
                    ST_KEYOK: begin
                        if (mclrn_s) begin
                            state_r   <= ST_PRE;
                            cnt_r     <= '0;
                            in_icsp_r <= 1'b1;
                        end
                    end
                    ST_PRE: begin
                        if (pgc_rise_s) begin
                            if (cnt_r == PRE_LAST) begin
                                state_r <= ST_FIRST;
                                cnt_r   <= '0;
                                shift_r <= 32'd0;
                            end else begin
                                cnt_r <= cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_FIRST, ST_SIX: begin
                        if (pgc_rise_s) begin
                            if (cnt_r == WORD_LAST) begin
                                instr_r       <= shift_next_s[23:0];
                                instr_valid_r <= 1'b1;
                                state_r       <= ST_CMD;
                                cnt_r         <= '0;
                                shift_r       <= 32'd0;
                            end else begin
                                shift_r <= shift_next_s;
                                cnt_r   <= cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_CMD: begin
                        if (pgc_rise_s) begin
                            if (cnt_r == CMD_LAST) begin
                                cnt_r   <= '0;
                                shift_r <= 32'd0;
                                case (shift_next_s[3:0])
                                    ICSP_SIX: begin
                                        state_r <= ST_SIX;
                                    end
                                    ICSP_REGOUT: begin
                                        state_r      <= ST_RIDLE;
                                        regout_req_r <= 1'b1;
                                    end
                                    default: begin
                                        state_r   <= ST_DISCARD;
                                        cmd_err_r <= 1'b1;
                                    end
                                endcase
                            end else begin
                                shift_r <= shift_next_s;
                                cnt_r   <= cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_DISCARD: begin
                        if (pgc_rise_s) begin
                            if (cnt_r == WORD_LAST) begin
                                state_r <= ST_CMD;
                                cnt_r   <= '0;
                            end else begin
                                cnt_r <= cnt_r + CNT_ONE;
                            end
                        end
                    end
                    ST_RIDLE: begin
                        if (pgc_rise_s && (cnt_r != IDLE_N)) begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end else if (pgc_fall_s && (cnt_r == IDLE_N)) begin
                            state_r    <= ST_ROUT;
                            cnt_r      <= '0;
                            pgdx_oe_r  <= 1'b1;
                            pgdx_out_r <= rdata_r[15];
                            rdata_r    <= {rdata_r[14:0], 1'b0};
                        end
                    end
                    ST_ROUT: begin
                        // host samples on rise; next bit goes out on the following fall
                        if (pgc_rise_s && (cnt_r != ROUT_BITS)) begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end else if (pgc_fall_s) begin
                            if (cnt_r == ROUT_BITS) begin
                                state_r    <= ST_CMD;
                                cnt_r      <= '0;
                                shift_r    <= 32'd0;
                                pgdx_oe_r  <= 1'b0;
                                pgdx_out_r <= 1'b0;
                            end else begin
                                pgdx_out_r <= rdata_r[15];
                                rdata_r    <= {rdata_r[14:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        state_r    <= ST_OFF;
                        cnt_r      <= '0;
                        in_icsp_r  <= 1'b0;
                        pgdx_oe_r  <= 1'b0;
                        pgdx_out_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign PGDx_out    = pgdx_out_r;
    assign PGDx_oe     = pgdx_oe_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign regout_req  = regout_req_r;
    assign in_icsp     = in_icsp_r;
    assign cmd_err     = cmd_err_r;
`ifdef ICSP_TGT_ENH_KEY_EN
    assign enh_mode    = enh_mode_r;
`endif

endmodule

// File: doc/pic24icsp_target.md
Name: pic24icsp_target

Overview:
Synthesizable ICSP target (responder) model for PIC24 serial programming. It lets the team's ICSP programmer be exercised on-FPGA and in simulation without a real device.
- Oversamples PGCx/PGDx/MCLRn on the system clock and validates the 32-bit entry key.
- Decodes SIX and REGOUT transactions.
- Presents received instructions to a back end and shifts back 16-bit register data on PGDx.

Parameters:
SYNC_STAGES, 2, synchronizer depth on PGCx/PGDx_in/MCLRn inputs (min 2)
ICSP_KEY, 32'h4D434851, accepted entry key
PRE_CLKS, 9, idle PGC clocks after MCLRn rise before first (command-less) SIX
REGOUT_IDLE, 8, PGC clocks between REGOUT command and first data bit

Ports:
clk  in  1  system clock; must be at least 4x PGCx frequency
rstn  in  1  asynchronous active-low reset
PGCx  in  1  programmer serial clock
MCLRn  in  1  programmer master clear
PGDx_in  in  1  serial data from programmer
PGDx_out  out  1  serial data to programmer
PGDx_oe  out  1  1 = target drives PGDx
instr  out  24  last received SIX instruction
instr_valid  out  1  1-cycle pulse; instr valid
regout_req  out  1  1-cycle pulse at REGOUT decode
regout_data  in  16  sampled on the cycle after regout_req
in_icsp  out  1  key accepted and MCLRn high
cmd_err  out  1  1-cycle pulse on unknown 4-bit command

Behaviour:
- Clock and reset: single clock `clk`. `rstn` is asynchronous and active-low.
- Reset values: all outputs 0; state OFF; shift registers 0.
- Input sampling: inputs pass through SYNC_STAGES flops. PGC rise/fall are detected on synchronized values; one-cycle edge strobes feed the FSM.
- Bit sampling: all programmer-to-target bits are sampled on PGC rise, MSB first (key, command, instruction).
- States:
  - OFF: MCLRn low -> KEY with shift count cleared.
  - KEY: shift 32 bits. MCLRn rise before 32 bits -> OFF. After 32 bits: match ICSP_KEY -> KEYOK, else -> KEYFAIL.
  - KEYFAIL: hold until MCLRn rises -> OFF.
  - KEYOK: wait MCLRn rise -> PRE; in_icsp=1 from that cycle.
  - PRE: count PRE_CLKS PGC rises, PGD ignored -> FIRST.
  - FIRST: 24 bits, no command field. Then instr updated and instr_valid pulses 1 cycle after the 24th rise -> CMD.
  - CMD: 4 bits.
    - 4'b0000 -> SIX.
    - 4'b0001 -> RIDLE, with regout_req pulse; regout_data latched next cycle.
    - Other -> cmd_err pulse, then DISCARD (24 clocks) -> CMD.
  - SIX: 24 bits; instr/instr_valid as in FIRST -> CMD.
  - RIDLE: count REGOUT_IDLE rises. On the fall after the last idle rise, PGDx_oe=1 and PGDx_out=latched[15] -> ROUT.
  - ROUT: on each subsequent PGC fall, shift the next bit (MSB first). On the fall after the 16th rise, PGDx_oe=0 and PGDx_out=0 -> CMD.
- Output-enable rule: PGDx_out is forced 0 whenever PGDx_oe=0.
- MCLRn low while in_icsp (any state past KEYOK): abort immediately.
  - in_icsp=0, PGDx_oe=0, no pulses.
  - -> KEY with a fresh count (re-entry).
- Simultaneous PGC edge and MCLRn change: MCLRn handling wins.
- regout_data changes after the latch cycle do not affect the transfer in progress.
- Counters are sized to the largest count, with no wrap. PGC edges in OFF/KEYFAIL/KEYOK are ignored.

Optional Feature:
ICSP_TGT_ENH_KEY_EN:
- When defined, KEY additionally accepts 32'h4D434850 (enhanced ICSP). Adds output `enh_mode` (1 bit), set on enhanced-key match and cleared on any abort/OFF. Decoding is otherwise unchanged.
- When undefined, only ICSP_KEY is accepted, 32'h4D434850 goes to KEYFAIL, and the port is absent.

Decomposition:
- Package pic24_icsp_pkg: command codes ICSP_SIX=4'b0000 and ICSP_REGOUT=4'b0001, ICSP_ENTER_CODE, ENH_ICSP_ENTER_CODE, target state enum. Shared with the programmer.
- Sub-module pic24icsp_sync: synchronizer plus PGC rise/fall strobe generation.

Test Plan:
- Key 0x4D434851, MCLRn rise, 9 idle clocks, 24 bits 0x000000 -> in_icsp=1; instr=0x000000 with one instr_valid pulse.
- After entry: CMD 0000 + 0x883C20 -> instr=0x883C20, one pulse, no cmd_err.
- CMD 0001 with regout_data=0xA5C3 -> regout_req pulse; 8 idle clocks; PGDx_oe high for exactly 16 clocks; host captures 0xA5C3; PGDx_oe=0 afterwards.
- Key 0x12345678 -> in_icsp stays 0 after MCLRn rise; subsequent PGC traffic gives no instr_valid.
- CMD 0110 + 24 bits, then SIX 0x040200 -> one cmd_err pulse; instr=0x040200 (resync holds).
- MCLRn low at bit 10 of ROUT -> PGDx_oe=0 within SYNC_STAGES+1 cycles, in_icsp=0; a new key 0x4D434851 re-enters. With ICSP_TGT_ENH_KEY_EN, key 0x4D434850 sets enh_mode=1.
